// File: rtl/mmu_arbiter.sv
// Shares one l1mmu line port between icache fills and dcache fills/write-backs.
// Each request is latched at grant and replayed to the l1mmu until mmu_done.
module mmu_arbiter #(
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned LINE_W   = 256
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic [31:0]       ic_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_read,
  output logic              mmu_write,
  output logic [31:0]       mmu_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StGrantI, StGrantD, StRespI, StRespD} state_e;

  state_e            state_q, state_d;
  logic              last_d_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              rd_q, wr_q;
  logic              dc_req, grant_i, grant_d, capture;

  assign dc_req = dc_read | dc_write;

  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ic_read && dc_req) begin
          // Fixed mode always favours icache; round-robin favours the side not served last.
          if (ARB_MODE == 1 || last_d_q) grant_i = 1'b1;
          else                           grant_d = 1'b1;
        end else begin
          grant_i = ic_read;
          grant_d = dc_req;
        end
        if (grant_i)      state_d = StGrantI;
        else if (grant_d) state_d = StGrantD;
      end
      StGrantI: begin
        if (mmu_done) begin
          capture = 1'b1;
          state_d = StRespI;
        end
      end
      StGrantD: begin
        if (mmu_done) begin
          capture = 1'b1;
          state_d = StRespD;
        end
      end
      StRespI, StRespD: state_d = StIdle;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      last_d_q <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        last_d_q <= 1'b0;
        addr_q   <= {ic_addr[31:5], 5'b0};
        wdata_q  <= '0;
        rd_q     <= 1'b1;
        wr_q     <= 1'b0;
      end else if (grant_d) begin
        // A simultaneous read and write request is serviced as a write-back.
        last_d_q <= 1'b1;
        addr_q   <= {dc_addr[31:5], 5'b0};
        wdata_q  <= dc_write_data;
        rd_q     <= ~dc_write;
        wr_q     <= dc_write;
      end
      if (capture) begin
        rdata_q <= mmu_read_data;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
      end
    end
  end

  assign mmu_read       = rd_q;
  assign mmu_write      = wr_q;
  assign mmu_addr       = addr_q;
  assign mmu_write_data = wdata_q;
  assign ic_read_data   = rdata_q;
  assign dc_read_data   = rdata_q;
  assign ic_done        = (state_q == StRespI);
  assign dc_done        = (state_q == StRespD);
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mmu_arbiter.sv
// Scoreboard bench for mmu_arbiter: an l1mmu responder model predicts grants and
// pushes expected completions; a monitor pops them when a done strobe appears.
module tb_mmu_arbiter;
  localparam int unsigned LW     = 256;
  localparam time         PERIOD = 10;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    bit    side;
    line_t data;
    time   t;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        ic_read, dc_read, dc_write;
  logic [31:0] ic_addr, dc_addr;
  line_t       dc_write_data;
  logic        ic_done, dc_done, mmu_read, mmu_write, busy;
  line_t       ic_read_data, dc_read_data, mmu_write_data;
  logic [31:0] mmu_addr;
  logic        mmu_done = 1'b0;
  line_t       mmu_read_data = '0;

  logic        ic_read1, dc_read1, dc_write1, mmu_done1;
  logic [31:0] ic_addr1, dc_addr1, mmu_addr1;
  line_t       dc_write_data1, mmu_read_data1;
  logic        ic_done1, dc_done1, mmu_read1, mmu_write1, busy1;
  line_t       ic_read_data1, dc_read_data1, mmu_write_data1;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  bit   done_log[$];

  int    lat_fix = -1;
  bit    data_fix_en = 1'b0;
  line_t data_fix = '0;
  bit    spur_hold_en = 1'b0;
  int    spur_req = 0;
  int    spur_ack = 0;

  always #(PERIOD / 2) sys_clk = ~sys_clk;

  mmu_arbiter #(.ARB_MODE(0), .LINE_W(LW)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_done(ic_done), .ic_read_data(ic_read_data),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr),
    .dc_write_data(dc_write_data), .dc_done(dc_done), .dc_read_data(dc_read_data),
    .mmu_read(mmu_read), .mmu_write(mmu_write), .mmu_addr(mmu_addr),
    .mmu_write_data(mmu_write_data), .mmu_done(mmu_done), .mmu_read_data(mmu_read_data),
    .busy(busy)
  );

  mmu_arbiter #(.ARB_MODE(1), .LINE_W(LW)) u_dut_fixed (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .ic_read(ic_read1), .ic_addr(ic_addr1), .ic_done(ic_done1), .ic_read_data(ic_read_data1),
    .dc_read(dc_read1), .dc_write(dc_write1), .dc_addr(dc_addr1),
    .dc_write_data(dc_write_data1), .dc_done(dc_done1), .dc_read_data(dc_read_data1),
    .mmu_read(mmu_read1), .mmu_write(mmu_write1), .mmu_addr(mmu_addr1),
    .mmu_write_data(mmu_write_data1), .mmu_done(mmu_done1), .mmu_read_data(mmu_read_data1),
    .busy(busy1)
  );

  function automatic line_t rand_line();
    line_t v;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_line(input string name, input line_t act, input line_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // l1mmu responder and grant model: arbitration rule applied to the request
  // levels the bench itself is driving.
  bit          s_busy = 1'b0, s_side = 1'b0, s_wr = 1'b0, s_last_d = 1'b1;
  bit          s_ext = 1'b0, s_chk_drop = 1'b0;
  int          s_cnt = 0;
  logic [31:0] s_addr = '0;
  line_t       s_data = '0;

  always @(posedge sys_clk) begin
    #1;
    if (!rst_n) begin
      s_busy = 1'b0; s_last_d = 1'b1; s_ext = 1'b0; s_chk_drop = 1'b0;
      mmu_done = 1'b0;
    end else begin
      if (mmu_done) begin
        if (spur_hold_en && !s_ext) begin
          s_ext = 1'b1;
          mmu_read_data = rand_line();
        end else begin
          mmu_done = 1'b0;
          s_ext = 1'b0;
        end
      end
      if (s_chk_drop) begin
        s_chk_drop = 1'b0;
        check_bit("mmu_req_drop", mmu_read | mmu_write, 1'b0);
      end else if (!s_busy && (mmu_read || mmu_write)) begin
        bit pi, pd;
        pi = ic_read;
        pd = dc_read | dc_write;
        check_bit("grant_has_request", pi | pd, 1'b1);
        s_side   = (pi && pd) ? !s_last_d : pd;
        s_last_d = s_side;
        s_addr   = (s_side ? dc_addr : ic_addr) & 32'hFFFF_FFE0;
        s_wr     = s_side && dc_write;
        s_data   = dc_write_data;
        check_word("grant_addr", mmu_addr, s_addr);
        check_bit("grant_write", mmu_write, s_wr);
        check_bit("grant_read", mmu_read, !s_wr);
        if (s_wr) check_line("grant_wdata", mmu_write_data, s_data);
        if (lat_fix >= 0) s_cnt = lat_fix;
        else              s_cnt = int'($urandom_range(0, 4));
        s_busy = 1'b1;
      end else if (s_busy) begin
        check_word("hold_addr", mmu_addr, s_addr);
        check_bit("hold_op", mmu_write & ~mmu_read, s_wr);
        check_bit("hold_req", mmu_write | mmu_read, 1'b1);
        if (s_wr) check_line("hold_wdata", mmu_write_data, s_data);
      end
      if (s_busy) begin
        if (s_cnt == 0) begin
          mmu_done      = 1'b1;
          mmu_read_data = data_fix_en ? data_fix : rand_line();
          s_ext         = 1'b0;
          exp_q.push_back('{s_side, mmu_read_data, $time});
          s_busy        = 1'b0;
          s_chk_drop    = 1'b1;
        end else begin
          s_cnt--;
        end
      end else if (spur_req != spur_ack && !mmu_done && !mmu_read && !mmu_write) begin
        mmu_done      = 1'b1;
        mmu_read_data = rand_line();
        s_ext         = 1'b1;
        spur_ack++;
      end
    end
  end

  // Completion monitor: each done must match the oldest expectation, one cycle after mmu_done.
  always @(posedge sys_clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else if (ic_done || dc_done) begin
      done_log.push_back(dc_done);
      if (exp_q.size() == 0 || exp_q[0].t != $time - PERIOD) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_done: got ic_done=%b dc_done=%b required no done", ic_done,
                 dc_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_bit("done_ic", ic_done, !e.side);
        check_bit("done_dc", dc_done, e.side);
        check_line("done_ic_data", ic_read_data, e.data);
        check_line("done_dc_data", dc_read_data, e.data);
      end
    end else if (exp_q.size() > 0 && exp_q[0].t == $time - PERIOD) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_missing: got no done required side=%0d", exp_q[0].side);
      void'(exp_q.pop_front());
    end
  end

  task automatic wait_done(input bit side, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(negedge sys_clk);
      if (side ? dc_done : ic_done) begin
        seen = 1'b1;
        cyc  = i;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL done_timeout side=%0d: got no done required one within 200 cycles", side);
    end
  endtask

  task automatic requester(input bit side, input int n, input bit rnd);
    int cyc;
    int op;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      if (rnd) repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      if (!side) begin
        ic_addr = $urandom;
        ic_read = 1'b1;
      end else begin
        op            = int'($urandom_range(0, 2));
        dc_addr       = $urandom;
        dc_write_data = rand_line();
        dc_read       = (op != 1);
        dc_write      = (op != 0);
      end
      wait_done(side, cyc);
      if (!side) ic_read = 1'b0;
      else begin
        dc_read  = 1'b0;
        dc_write = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_busy"}, busy, 1'b0);
    check_bit({tag, "_done"}, ic_done | dc_done, 1'b0);
    check_bit({tag, "_mmu_req"}, mmu_read | mmu_write, 1'b0);
    check_word({tag, "_mmu_addr"}, mmu_addr, 32'h0);
    check_line({tag, "_wdata"}, mmu_write_data, '0);
    check_line({tag, "_ic_rdata"}, ic_read_data, '0);
    check_line({tag, "_dc_rdata"}, dc_read_data, '0);
  endtask

  initial begin
    int    cyc;
    int    k;
    bit    got;
    line_t d;
    rst_n = 1'b0;
    ic_read = 1'b0; ic_addr = '0; dc_read = 1'b0; dc_write = 1'b0; dc_addr = '0;
    dc_write_data = '0;
    ic_read1 = 1'b0; ic_addr1 = '0; dc_read1 = 1'b0; dc_write1 = 1'b0; dc_addr1 = '0;
    dc_write_data1 = '0; mmu_done1 = 1'b0; mmu_read_data1 = '0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // icache fill, l1mmu answers in the fourth request cycle
    @(negedge sys_clk);
    lat_fix = 3; data_fix_en = 1'b1; data_fix = {32{8'hA5}};
    ic_addr = 32'h0000_1234; ic_read = 1'b1;
    @(posedge sys_clk); #1;
    check_bit("i_mmu_read", mmu_read, 1'b1);
    check_word("i_mmu_addr", mmu_addr, 32'h0000_1220);
    check_bit("i_busy", busy, 1'b1);
    wait_done(1'b0, cyc);
    check_word("i_latency", cyc, 32'd5);
    check_line("i_data", ic_read_data, {32{8'hA5}});
    check_bit("i_no_dc_done", dc_done, 1'b0);
    ic_read = 1'b0; data_fix_en = 1'b0;

    // dcache write-back, then read+write together
    @(negedge sys_clk);
    lat_fix = 2;
    dc_addr = 32'h1000_003F; dc_write_data = {32{8'h55}}; dc_write = 1'b1;
    @(posedge sys_clk); #1;
    check_bit("d_mmu_write", mmu_write, 1'b1);
    check_bit("d_mmu_read", mmu_read, 1'b0);
    check_word("d_mmu_addr", mmu_addr, 32'h1000_0020);
    check_line("d_mmu_wdata", mmu_write_data, {32{8'h55}});
    wait_done(1'b1, cyc);
    dc_write = 1'b0;
    @(negedge sys_clk);
    dc_read = 1'b1; dc_write = 1'b1; dc_addr = 32'h0000_0FFF;
    @(posedge sys_clk); #1;
    check_bit("rw_as_write", mmu_write & ~mmu_read, 1'b1);
    wait_done(1'b1, cyc);
    dc_read = 1'b0; dc_write = 1'b0;
    lat_fix = -1;

    // round-robin ties: both raised together, re-requests on the idle cycle
    k = done_log.size();
    fork
      requester(1'b0, 2, 1'b0);
      requester(1'b1, 2, 1'b0);
    join
    check_word("rr_count", done_log.size(), k + 4);
    if (done_log.size() >= k + 4)
      check_word("rr_order", {28'd0, done_log[k], done_log[k+1], done_log[k+2], done_log[k+3]},
                 32'b0101);

    // spurious mmu_done in idle and held into the response cycle
    @(negedge sys_clk);
    spur_req = spur_req + 1;
    repeat (3) begin
      @(negedge sys_clk);
      check_bit("spur_idle_busy", busy, 1'b0);
    end
    spur_hold_en = 1'b1;
    requester(1'b0, 1, 1'b0);
    spur_hold_en = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_bit("spur_resp_idle", busy, 1'b0);

    // asynchronous reset two cycles into a dcache grant
    lat_fix = 20;
    dc_addr = 32'h2000_0040; dc_read = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge sys_clk);
      got = mmu_read;
    end
    check_bit("rst_grant_seen", got, 1'b1);
    repeat (2) @(negedge sys_clk);
    ic_addr = 32'h0000_3000; ic_read = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge sys_clk);
    check_bit("rst_held_busy", busy, 1'b0);
    lat_fix = -1;
    k = done_log.size();
    rst_n = 1'b1;
    wait_done(1'b0, cyc);
    ic_read = 1'b0;
    wait_done(1'b1, cyc);
    dc_read = 1'b0;
    check_word("post_rst_count", done_log.size(), k + 2);
    if (done_log.size() >= k + 2)
      check_word("post_rst_order", {30'd0, done_log[k], done_log[k+1]}, 32'b01);

    // randomized traffic
    fork
      requester(1'b0, 25, 1'b1);
      requester(1'b1, 25, 1'b1);
    join

    // fixed priority: icache re-requesting starves dcache
    @(negedge sys_clk);
    ic_addr1 = 32'h0000_0040; ic_read1 = 1'b1;
    dc_addr1 = 32'h0000_0080; dc_read1 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge sys_clk);
        got = mmu_read1 | mmu_write1;
      end
      check_bit("fx_grant", got, 1'b1);
      check_word("fx_addr", mmu_addr1, 32'h0000_0040);
      mmu_done1 = 1'b1;
      mmu_read_data1 = rand_line();
      d = mmu_read_data1;
      @(negedge sys_clk);
      mmu_done1 = 1'b0;
      check_word("fx_done", {30'd0, ic_done1, dc_done1}, 32'b10);
      check_line("fx_data", ic_read_data1, d);
      ic_read1 = 1'b0;
      @(negedge sys_clk);
      ic_read1 = 1'b1;
    end
    ic_read1 = 1'b0; dc_read1 = 1'b0;

    repeat (4) @(negedge sys_clk);
    check_word("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
